// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus between the boot byte source and the loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: reads a 16-bit word count then big-endian words from a byte stream,
// writes them to consecutive memory words and holds the CPU until the load completes.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        in_ready;
  logic        fire;
  logic [15:0] hdr_len;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign fire     = bus.in_valid && in_ready;
  assign hdr_len  = {len_q[15:8], bus.in_data};

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LEN_HI;
      len_q      <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (fire) begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (fire) begin
          len_d[7:0] = bus.in_data;
          index_d    = '0;
          byte_cnt_d = '0;
          if (hdr_len == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, hdr_len} > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address and data are latched here so they stay stable after the write.
            wdata_d = {shift_q, bus.in_data};
            addr_d  = BASE_ADDR + (32'(index_q) << 2);
            state_d = S_WRITE;
          end else begin
            shift_d = {shift_q[15:0], bus.in_data};
          end
        end
      end
      S_WRITE: begin
        index_d    = index_q + 1'b1;
        byte_cnt_d = '0;
        if (32'(index_q) + 32'd1 == {16'd0, len_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          index_d    = '0;
          byte_cnt_d = '0;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized checks of two loader instances (capacity 256 words at base 0, capacity 4 words
// at base 0x100) against an expected-write list computed directly from the byte stream.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct { int dut; int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int dut; int cyc; } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic hold_a, done_a, err_a;
  logic hold_b, done_b, err_b;

  prog_loader_if ifa ();
  prog_loader_if ifb ();

  prog_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa.slave),
    .cpu_hold(hold_a), .done(done_a), .err(err_a)
  );

  prog_loader #(.ADDR_W(2), .BASE_ADDR(32'h0000_0100)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb.slave),
    .cpu_hold(hold_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t wr_q[$];
  ev_t acc_q[$];
  ev_t rise_q[$];
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;

  always @(negedge clk) begin
    if (ifa.in_valid && ifa.in_ready) acc_q.push_back('{0, cyc});
    if (ifb.in_valid && ifb.in_ready) acc_q.push_back('{1, cyc});
    if (ifa.mem_we) wr_q.push_back('{0, cyc, ifa.mem_addr, ifa.mem_wdata});
    if (ifb.mem_we) wr_q.push_back('{1, cyc, ifb.mem_addr, ifb.mem_wdata});
    if (done_a && !done_a_prev) rise_q.push_back('{0, cyc});
    if (done_b && !done_b_prev) rise_q.push_back('{1, cyc});
    done_a_prev <= done_a;
    done_b_prev <= done_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return d != 0 ? ifb.in_ready : ifa.in_ready;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] x);
    if (d != 0) begin
      ifb.in_valid = v;
      ifb.in_data  = x;
    end else begin
      ifa.in_valid = v;
      ifa.in_data  = x;
    end
  endtask

  task automatic chk_outputs(input int d, input string tag, input logic rdy_e, input logic hold_e,
                             input logic done_e, input logic err_e);
    if (d != 0) begin
      chk({tag, "_in_ready"}, 32'(ifb.in_ready), 32'(rdy_e));
      chk({tag, "_mem_we"}, 32'(ifb.mem_we), 32'd0);
      chk({tag, "_cpu_hold"}, 32'(hold_b), 32'(hold_e));
      chk({tag, "_done"}, 32'(done_b), 32'(done_e));
      chk({tag, "_err"}, 32'(err_b), 32'(err_e));
    end else begin
      chk({tag, "_in_ready"}, 32'(ifa.in_ready), 32'(rdy_e));
      chk({tag, "_mem_we"}, 32'(ifa.mem_we), 32'd0);
      chk({tag, "_cpu_hold"}, 32'(hold_a), 32'(hold_e));
      chk({tag, "_done"}, 32'(done_a), 32'(done_e));
      chk({tag, "_err"}, 32'(err_a), 32'(err_e));
    end
  endtask

  // mode 0: in_valid always 1; mode 1: toggles every cycle; mode 2: random.
  task automatic drive(input int d, input byte_q_t bytes, input int mode);
    int i = 0;
    int n = 0;
    logic v;
    logic fire;
    while (i < bytes.size() && n < 8000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      set_in(d, v, v ? bytes[i] : 8'($urandom));
      @(negedge clk);
      fire = v && rdy(d);
      @(posedge clk);
      #1;
      if (fire) i++;
      n++;
    end
    set_in(d, 1'b0, 8'($urandom));
    chk("stream_complete", 32'(i), 32'(bytes.size()));
  endtask

  task automatic run(input int d, input byte_q_t bytes, input int mode, input string tag);
    int wb = wr_q.size();
    int ab = acc_q.size();
    int rb = rise_q.size();
    int n, cap, nw;
    logic ok;
    logic [31:0] base, exp_data;
    wr_t wrs[$];
    ev_t accs[$];
    int rise_cyc = -1;
    int exp_rise;

    drive(d, bytes, mode);
    repeat (4) @(posedge clk);
    #1;

    for (int k = wb; k < wr_q.size(); k++) if (wr_q[k].dut == d) wrs.push_back(wr_q[k]);
    for (int k = ab; k < acc_q.size(); k++) if (acc_q[k].dut == d) accs.push_back(acc_q[k]);
    for (int k = rb; k < rise_q.size(); k++)
      if (rise_q[k].dut == d && rise_cyc < 0) rise_cyc = rise_q[k].cyc;

    n    = {bytes[0], bytes[1]};
    cap  = d != 0 ? 4 : 256;
    base = d != 0 ? 32'h100 : 32'h0;
    ok   = (n != 0) && (n <= cap);
    nw   = ok ? n : 0;

    chk({tag, "_bytes_consumed"}, 32'(accs.size()), 32'(bytes.size()));
    chk({tag, "_write_count"}, 32'(wrs.size()), 32'(nw));
    for (int k = 0; k < nw && k < wrs.size(); k++) begin
      exp_data = {bytes[2+4*k], bytes[3+4*k], bytes[4+4*k], bytes[5+4*k]};
      chk({tag, "_addr"}, wrs[k].addr, base + 32'(4 * k));
      chk({tag, "_data"}, wrs[k].data, exp_data);
      if (accs.size() > 5 + 4 * k)
        chk({tag, "_latency"}, 32'(wrs[k].cyc - accs[5+4*k].cyc), 32'd1);
    end
    chk_outputs(d, tag, 1'b0, n > cap, n <= cap, n > cap);
    if (n <= cap) begin
      if (n == 0) exp_rise = accs.size() > 1 ? accs[1].cyc + 1 : -2;
      else        exp_rise = wrs.size() > 0 ? wrs[wrs.size()-1].cyc + 1 : -2;
      chk({tag, "_done_rise_cycle"}, 32'(rise_cyc), 32'(exp_rise));
    end
    if (ok && wrs.size() == nw) begin
      chk({tag, "_addr_hold"}, d != 0 ? ifb.mem_addr : ifa.mem_addr, base + 32'(4 * (n - 1)));
      chk({tag, "_wdata_hold"}, d != 0 ? ifb.mem_wdata : ifa.mem_wdata,
          {bytes[4*n-2], bytes[4*n-1], bytes[4*n], bytes[4*n+1]});
    end
    $display("txn %s dut=%0d N=%0d mode=%0d writes=%0d done=%0b err=%0b", tag, d, n, mode,
             wrs.size(), d != 0 ? done_b : done_a, d != 0 ? err_b : err_a);
  endtask

  task automatic rearm(input int d, input string tag);
    if (d != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk_outputs(d, tag, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic byte_q_t make_prog(input int n);
    byte_q_t s;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t s;
    int wb;

    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    set_in(0, 1'b1, 8'h55);
    set_in(1, 1'b1, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    chk_outputs(0, "reset_a", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_outputs(1, "reset_b", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_a_addr", ifa.mem_addr, 32'h0);
    chk("reset_a_wdata", ifa.mem_wdata, 32'h0);
    chk("reset_b_addr", ifb.mem_addr, 32'h100);
    chk("reset_b_wdata", ifb.mem_wdata, 32'h0);
    rst = 1'b1;

    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    run(0, s, 0, "two_words");
    rearm(0, "rearm_two_words");
    run(0, s, 1, "two_words_toggle");
    rearm(0, "rearm_toggle");

    s = '{8'h00, 8'h00};
    run(0, s, 0, "zero_len");
    rearm(0, "rearm_zero_len");

    s = '{8'h01, 8'h01};
    run(0, s, 0, "over_capacity");
    rearm(0, "rearm_over_capacity");

    run(1, make_prog(4), 2, "small_full");
    rearm(1, "rearm_small_full");
    s = '{8'h00, 8'h05};
    run(1, s, 0, "small_over");
    rearm(1, "rearm_small_over");
    run(1, make_prog(1), 0, "small_one");
    rearm(1, "rearm_small_one");

    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    wb = wr_q.size();
    drive(0, s, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_write", 32'(wr_q.size() - wb), 32'd0);
    chk_outputs(0, "midreset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midreset_addr", ifa.mem_addr, 32'h0);
    chk("midreset_wdata", ifa.mem_wdata, 32'h0);
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    run(0, s, 2, "after_reset_reload");
    rearm(0, "rearm_after_reset");

    for (int t = 0; t < 6; t++) begin
      run(0, make_prog(int'($urandom_range(1, 6))), int'($urandom_range(0, 2)), "random");
      rearm(0, "rearm_random");
    end

    run(0, make_prog(256), 0, "full_capacity");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, word-address width; maximum program size is 2^ADDR_W words.
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0000_0000, byte address of first program word (word aligned).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  single-cycle pulse re-arming the loader from DONE or ERR.
REQ-006 SHALL have port: in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port: in_data  input  8  byte-stream data.
REQ-008 SHALL have port: in_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port: mem_we  output  1  memory word-write strobe.
REQ-010 SHALL have port: mem_addr  output  32  memory byte address.
REQ-011 SHALL have port: mem_wdata  output  32  memory write data.
REQ-012 SHALL have port: cpu_hold  output  1  active-high hold; drives the CPU PC reset until the program is loaded.
REQ-013 SHALL have port: done  output  1  load completed successfully.
REQ-014 SHALL have port: err  output  1  length header exceeded capacity.

Function
REQ-015 SHALL transfer a byte only on a clk edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-016 SHALL implement states LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-017 SHALL drive in_ready=1 in LEN_HI, LEN_LO and DATA; 0 in WRITE, DONE and ERR.
REQ-018 LEN_HI: accepted byte SHALL become word-count bits [15:8]; go to LEN_LO.
REQ-019 LEN_LO: accepted byte SHALL become word-count bits [7:0]; N=0 -> DONE; N>2^ADDR_W -> ERR; otherwise -> DATA with word index 0 and byte count 0.
REQ-020 DATA: bytes SHALL assemble big-endian (first byte -> bits [31:24]); the 4th byte -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*index.
REQ-022 On leaving WRITE, index SHALL increment; if index+1=N -> DONE, else -> DATA.
REQ-023 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-024 Latency: mem_we SHALL be high in the cycle immediately following the edge that accepts the 4th byte of a word.
REQ-025 Throughput: one word SHALL occupy 5 cycles minimum (4 accept + 1 write).
REQ-026 cpu_hold SHALL be 1 in all states except DONE; it SHALL fall in the first cycle of DONE.
REQ-027 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; both sticky until start or reset.
REQ-028 start=1 in DONE or ERR SHALL go to LEN_HI with cpu_hold=1, done=0, err=0, index cleared; start SHALL be ignored in all other states.
REQ-029 Index arithmetic SHALL be ADDR_W+1 bits so N=2^ADDR_W is accepted without wrap; last address = BASE_ADDR+4*(2^ADDR_W-1).
REQ-030 Word-count width is 16 bits; N is compared unsigned.

Reset
REQ-031 On a clk edge with rst=0 the block SHALL enter LEN_HI with in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, err=0, index=0, byte count=0.
REQ-032 Reset mid-operation (any state, including WRITE) SHALL discard any partial word and SHALL NOT issue a further memory write.
REQ-033 rst=0 SHALL take priority over start and over any byte transfer in the same cycle.

Verification
REQ-034 Bytes 00 02 | 20 08 00 05 | AC 08 00 00, in_valid always 1, BASE_ADDR=0 -> two single-cycle writes: (0x00, 0x20080005) then (0x04, 0xAC080000); done=1, cpu_hold=0 in cycle after 2nd write.
REQ-035 Header 00 00 -> DONE directly after LEN_LO, mem_we never asserted, cpu_hold falls.
REQ-036 ADDR_W=8, header 01 01 (N=257) -> err=1, in_ready=0, cpu_hold stays 1, no writes; start pulse -> LEN_HI, err=0.
REQ-037 Same stream as REQ-034 with in_valid toggling 1/0 every cycle -> identical writes and data; in_valid=1 during WRITE does not consume a byte.
REQ-038 rst=0 asserted on the cycle after 3rd data byte of word 1 -> no write issued; after release, full 2-word reload completes correctly.
REQ-039 ADDR_W=2, N=4 -> last write at 0x0C, done=1; start in DONE reloads with cpu_hold reasserted.
